iob_split_reg: RTL
==================

Name: iob_split_reg

Overview:
- Parametrised, registered successor to the combinational native-bus splitter used on the instruction, data and peripheral buses.
- Routes one master native-bus transaction to one of N_SLAVES, selected by address bits.
- Registers the request, holds the slave handshake until the slave responds, and returns the response to the master.
- Adds behaviour the plain splitter does not have: an error response for unmapped selections and an optional per-transaction timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- N_SLAVES, 3, number of slave ports; must be >= 1.
- P_SLAVES, 31, MSB position of the slave-select field in m_addr.
- SEL_W, $clog2(N_SLAVES) (1 when N_SLAVES=1), select field width; field is m_addr[P_SLAVES -: SEL_W].
- ERR_DATA, 32'hDEADBEEF, rdata returned on an error response.
- TIMEOUT, 1024, cycles to wait for s_ready; only used with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- m_valid  in  1  master request valid; held until m_ready.
- m_addr  in  ADDR_W  master address.
- m_wdata  in  DATA_W  master write data.
- m_wstrb  in  DATA_W/8  write strobes; 0 means read.
- m_rdata  out  DATA_W  response data.
- m_ready  out  1  one-cycle response strobe.
- s_valid  out  N_SLAVES  per-slave request valid.
- s_addr  out  N_SLAVES*ADDR_W  request address; same registered value on every slice.
- s_wdata  out  N_SLAVES*DATA_W  write data; broadcast.
- s_wstrb  out  N_SLAVES*DATA_W/8  strobes; broadcast.
- s_rdata  in  N_SLAVES*DATA_W  slave read data; slice i belongs to slave i.
- s_ready  in  N_SLAVES  slave response strobe.
- err  out  1  one-cycle pulse on an unmapped or timeout response.
- err_sel  out  SEL_W  select value of the last errored transaction.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE.
  - s_valid=0, m_ready=0, m_rdata=0.
  - err=0, err_sel=0, request registers=0, timeout counter=0.
  - Reset aborts any in-flight transaction with no response to the master.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - On m_valid=1, latch addr/wdata/wstrb and sel.
  - If sel < N_SLAVES, go to REQ.
  - Otherwise go to RESP with m_rdata=ERR_DATA, err=1, err_sel=sel.
- REQ:
  - s_valid[sel]=1; all other s_valid bits are 0.
  - s_addr/s_wdata/s_wstrb are driven from the registered request.
  - When s_ready[sel]=1: capture s_rdata[sel] into m_rdata, drop s_valid, go to RESP.
  - s_ready on non-selected slaves is ignored.
- RESP:
  - m_ready=1 for exactly one cycle, then go to IDLE.
  - m_valid is ignored in this cycle.
  - The master drops or changes m_valid before the next IDLE cycle.
- Latency:
  - Request accepted at cycle N; s_valid high at N+1.
  - If s_ready arrives at N+1, m_ready is high at N+2.
  - An unmapped request gives m_ready at N+1.
- m_rdata is held stable after m_ready until the next capture.
- Writes follow the same path; the slave's rdata is forwarded unchanged.
- Only one transaction is outstanding at a time; there is no reordering.

Optional Feature:
- Macro: IOB_SPLIT_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT)+1-bit counter clears on entry to REQ and increments each REQ cycle.
  - When it reaches TIMEOUT-1 with s_ready[sel]=0: drop s_valid, go to RESP with m_rdata=ERR_DATA, err=1, err_sel=sel.
  - If s_ready[sel]=1 in the same cycle as the timeout, the ready wins: normal data is returned and no err.
- Not defined: no counter logic; REQ waits indefinitely for s_ready.

Test Plan:
1. N_SLAVES=3, P_SLAVES=31. Read m_addr=0x4000_0010; slave1 gives s_ready at N+3 with rdata 0x1234_5678 -> s_valid=3'b010 from N+1 to N+3; m_ready at N+4 with m_rdata=0x1234_5678; err=0.
2. Write m_addr=0x0000_0020, wdata=0xA5A5_A5A5, wstrb=4'hF; slave0 ready at N+1 -> s_wdata/s_wstrb match; m_ready at N+2; s_valid[2:1] stays 0.
3. Unmapped m_addr=0xC000_0000 (sel=3) -> no s_valid; m_ready and err at N+1; m_rdata=0xDEADBEEF; err_sel=3.
4. IOB_SPLIT_TIMEOUT_EN, TIMEOUT=16, slave2 never ready -> s_valid[2] high for 16 cycles then low; m_ready with 0xDEADBEEF and err=1, err_sel=2. Repeat with s_ready arriving on the timeout cycle -> normal data, err=0.
5. rst=0 in the second REQ cycle -> next cycle s_valid=0, m_ready=0, state=IDLE. After release, a fresh read to slave0 completes normally.
6. Back-to-back: m_valid re-asserted with a new address immediately after m_ready -> second request latched on the first IDLE cycle; no request lost or duplicated.

Source files
------------

// File: rtl/iob_split_reg_if.sv
// Native-bus bundle for iob_split_reg: master-side request/response plus the
// per-slave request/response vectors. "slave" is the splitter's view.
interface iob_split_reg_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 3
);
  logic                           m_valid;
  logic [ADDR_W-1:0]              m_addr;
  logic [DATA_W-1:0]              m_wdata;
  logic [DATA_W/8-1:0]            m_wstrb;
  logic [DATA_W-1:0]              m_rdata;
  logic                           m_ready;
  logic [N_SLAVES-1:0]            s_valid;
  logic [N_SLAVES*ADDR_W-1:0]     s_addr;
  logic [N_SLAVES*DATA_W-1:0]     s_wdata;
  logic [N_SLAVES*DATA_W/8-1:0]   s_wstrb;
  logic [N_SLAVES*DATA_W-1:0]     s_rdata;
  logic [N_SLAVES-1:0]            s_ready;

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  m_rdata, m_ready,
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_rdata, s_ready
  );

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output m_rdata, m_ready,
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_rdata, s_ready
  );
endinterface

// File: rtl/iob_split_reg.sv
// Registered native-bus splitter: one outstanding master transaction routed to
// one of N_SLAVES by address bits. Optional REQ timeout via IOB_SPLIT_TIMEOUT_EN.
module iob_split_reg #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                N_SLAVES = 3,
  parameter int                P_SLAVES = 31,
  parameter int                SEL_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF),
  parameter int                TIMEOUT  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  iob_split_reg_if.slave     bus,
  output logic               err,
  output logic [SEL_W-1:0]   err_sel
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [SEL_W:0] N_SEL = (SEL_W+1)'(N_SLAVES);

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [SEL_W-1:0]  err_sel_q, err_sel_d;

  logic [SEL_W-1:0]  m_sel;
  logic              sel_mapped;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;

`ifdef IOB_SPLIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign m_sel      = bus.m_addr[P_SLAVES -: SEL_W];
  assign sel_mapped = {1'b0, m_sel} < N_SEL;

  // Only the selected slave's ready/rdata are looked at; the rest are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ready = bus.s_ready[i];
        sel_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    bus.s_valid = '0;
    if (state_q == REQ) begin
      for (int unsigned i = 0; i < N_SLAVES; i++) begin
        bus.s_valid[i] = (sel_q == SEL_W'(i));
      end
    end
  end

  assign bus.s_addr  = {N_SLAVES{addr_q}};
  assign bus.s_wdata = {N_SLAVES{wdata_q}};
  assign bus.s_wstrb = {N_SLAVES{wstrb_q}};
  assign bus.m_rdata = rdata_q;
  assign bus.m_ready = (state_q == RESP);
  assign err         = err_q;
  assign err_sel     = err_sel_q;

  // err_d defaults low so the error flag lives exactly as long as RESP.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    err_sel_d = err_sel_q;
`ifdef IOB_SPLIT_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.m_valid) begin
          sel_d   = m_sel;
          addr_d  = bus.m_addr;
          wdata_d = bus.m_wdata;
          wstrb_d = bus.m_wstrb;
          if (sel_mapped) begin
            state_d = REQ;
`ifdef IOB_SPLIT_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d   = RESP;
            rdata_d   = ERR_DATA;
            err_d     = 1'b1;
            err_sel_d = m_sel;
          end
        end
      end
      REQ: begin
        if (sel_ready) begin
          rdata_d = sel_rdata;
          state_d = RESP;
        end
`ifdef IOB_SPLIT_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = RESP;
          rdata_d   = ERR_DATA;
          err_d     = 1'b1;
          err_sel_d = sel_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_sel_q <= '0;
`ifdef IOB_SPLIT_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_sel_q <= err_sel_d;
`ifdef IOB_SPLIT_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule
